// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load type encodings and default sizes.
package wb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    typedef enum logic [1:0] {
        LD_WORD  = 2'b00,
        LD_HALF  = 2'b01,
        LD_BYTE  = 2'b10,
        LD_BYTEU = 2'b11
    } load_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: selects the addressed half/byte lane of a
// little-endian memory word and sign- or zero-extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [1:0]        ByteSel,
    input  logic [1:0]        LoadType,
    output logic [DATA_W-1:0] LoadData
);

    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;

    function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
        return DATA_W'(v);
    endfunction

    // Halfword selection deliberately ignores ByteSel[0]; misaligned halves are not trapped.
    always_comb begin
        half_s = ByteSel[1] ? MemReadData[31:16] : MemReadData[15:0];
        byte_s = MemReadData[7:0];
        case (ByteSel)
            2'd0:    byte_s = MemReadData[7:0];
            2'd1:    byte_s = MemReadData[15:8];
            2'd2:    byte_s = MemReadData[23:16];
            default: byte_s = MemReadData[31:24];
        endcase
    end

    always_comb begin
        LoadData = MemReadData;
        case (load_t'(LoadType))
            LD_WORD:  LoadData = MemReadData;
            LD_HALF:  LoadData = sext16(half_s);
            LD_BYTE:  LoadData = sext8(byte_s);
            LD_BYTEU: LoadData = zext8(byte_s);
            default:  LoadData = MemReadData;
        endcase
    end

endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage and architectural register file with two combinational read ports.
// Optional macro WB_BYPASS_EN forwards a same-cycle write onto matching read ports.
module wb_reg_file
    import wb_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [DATA_W-1:0] ALUResultIn,
    input  logic [IDX_W-1:0]  RegAddressIn,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic [1:0]        LoadType,
    input  logic [IDX_W-1:0]  ReadReg1,
    input  logic [IDX_W-1:0]  ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WBData,
    output logic              WBValid
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] arr_rd1;
    logic [DATA_W-1:0] arr_rd2;

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .MemReadData (MemReadData),
        .ByteSel     (ALUResultIn[1:0]),
        .LoadType    (LoadType),
        .LoadData    (load_data)
    );

    assign WBData  = MemToReg ? load_data : ALUResultIn;
    assign WBValid = RegWrite && (RegAddressIn != '0);

    // Reset clears the whole array and wins over any concurrent write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WBValid) begin
            regs[RegAddressIn] <= WBData;
        end
    end

    assign arr_rd1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
    assign arr_rd2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];

`ifdef WB_BYPASS_EN
    // WBValid already excludes index 0, so register 0 never picks up forwarded data.
    assign ReadData1 = (WBValid && (ReadReg1 == RegAddressIn)) ? WBData : arr_rd1;
    assign ReadData2 = (WBValid && (ReadReg2 == RegAddressIn)) ? WBData : arr_rd2;
`else
    assign ReadData1 = arr_rd1;
    assign ReadData2 = arr_rd2;
`endif

endmodule

// File: doc/wb_reg_file.md
WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 Parameter: DATA_W, default 32, datapath and register width.
REQ-002 Parameter: NUM_REGS, default 32, number of architectural registers; index width is log2(NUM_REGS) = 5.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of Clk only.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 MemReadData  input  32  raw word from the MEM/WB register.
REQ-007 ALUResultIn  input  32  ALU result or load address from the MEM/WB register.
REQ-008 RegAddressIn  input  5  destination register index.
REQ-009 RegWrite  input  1  write-back enable.
REQ-010 MemToReg  input  1  1 selects the load path, 0 selects ALUResultIn.
REQ-011 LoadType  input  2  00 word, 01 signed half, 10 signed byte, 11 unsigned byte.
REQ-012 ReadReg1, ReadReg2  input  5 each  read port indices.
REQ-013 ReadData1, ReadData2  output  32 each  read port data, combinational.
REQ-014 WBData  output  32  selected write-back value, combinational, for EX forwarding.
REQ-015 WBValid  output  1  RegWrite & (RegAddressIn != 0), combinational.

Function
REQ-016 Load path SHALL extract data by ALUResultIn[1:0], little-endian.
- Half: bit 1 selects bits [31:16] or [15:0].
- Byte: bits [1:0] select lane 3..0.
REQ-017 Extension: signed types SHALL sign-extend to 32 bits; unsigned byte SHALL zero-extend; word SHALL pass unchanged and ignore ALUResultIn[1:0].
REQ-018 WBData SHALL be the load-path value when MemToReg=1, else ALUResultIn.
REQ-019 On a rising edge with Reset=0 and WBValid=1, the register at RegAddressIn SHALL take WBData; write latency is 1 cycle.
REQ-020 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-021 Reads SHALL return the current array content; a read of an index not written since reset SHALL return 0.
REQ-022 A simultaneous write and read of the same nonzero index SHALL follow REQ-031/REQ-032.
REQ-023 Both read ports SHALL operate independently, including both reading the same index.
REQ-024 Halfword loads with ALUResultIn[0]=1 SHALL still use bit 1 only; no alignment exception is raised.

Reset
REQ-025 While Reset=1 at a rising edge, all registers SHALL clear to 0 and any concurrent write SHALL be dropped; Reset has priority.
REQ-026 From the first edge after Reset, ReadData1 and ReadData2 SHALL return 0 for every index.
REQ-027 WBData and WBValid are combinational and SHALL follow their inputs regardless of Reset.
REQ-028 A write on the first edge after Reset deasserts SHALL take effect normally.

Configuration
REQ-029 Macro WB_BYPASS_EN selects same-cycle write-to-read forwarding.
REQ-030 The macro SHALL change only the same-cycle read behaviour; all other behaviour is identical with or without it.
REQ-031 With WB_BYPASS_EN defined: when WBValid=1 and ReadRegN == RegAddressIn, ReadDataN SHALL equal WBData in the same cycle.
REQ-032 Without WB_BYPASS_EN: ReadDataN SHALL return the pre-write value until the next cycle.

Structure
REQ-033 Shared package wb_pkg SHALL hold the LoadType encodings (LD_WORD, LD_HALF, LD_BYTE, LD_BYTEU) and the DATA_W and NUM_REGS defaults.
REQ-034 Sub-module wb_load_align SHALL be combinational and implement REQ-016/REQ-017; the register array and ports stay in wb_reg_file.

Verification
REQ-035 Reset, then read all 32 indices -> every ReadData = 0x00000000.
REQ-036 MemToReg=0, ALUResultIn=0x12345678, RegAddressIn=5, RegWrite=1; read 5 next cycle -> 0x12345678; same write to index 0 -> register 0 still reads 0.
REQ-037 MemToReg=1, MemReadData=0x80FF7F01:
- Signed byte, addr[1:0]=3 -> 0xFFFFFF80.
- Unsigned byte, lane 3 -> 0x00000080.
- Signed half, addr[1]=0 -> 0x00007F01.
- Signed half, addr[1]=1 -> 0xFFFF80FF.
REQ-038 Write 0xDEADBEEF to index 7 while ReadReg1=7 -> same cycle 0xDEADBEEF with WB_BYPASS_EN defined, prior value without it; next cycle 0xDEADBEEF in both builds.
REQ-039 Reset=1 together with RegWrite=1 to index 9, value 0xAAAAAAAA -> index 9 reads 0; the write on the following edge with Reset=0 lands.
REQ-040 ReadReg1=ReadReg2=12 after writing 0x0000CAFE -> both ports = 0x0000CAFE.
